id_ex_forward_stage: RTL
========================

// Module: id_ex_forward_stage
// PURPOSE
//  ID/EX pipeline register and the consumer of the hazard unit's forward_a/forward_b/stall.
//  Selects forwarded operands, captures them into EX and injects bubbles on stall/flush.
//  A run-length monitor flags stalls that never resolve.
//  Sits between the decode register-file read and the ALU.
// PARAMETERS
//  DATA_W     8   operand/result width in bits
//  MAX_STALL  15  consecutive stall cycles that trip stall_timeout (1..255)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       synchronous, active-low reset
//  stall          in   1       hazard-unit stall request
//  flush          in   1       branch/redirect flush of the decode slot
//  forward_a      in   2       rs source: 00 regfile, 11 EX, 01 MEM, 10 WB
//  forward_b      in   2       rt source, same encoding
//  rf_rs_data     in   DATA_W  register-file read port A
//  rf_rt_data     in   DATA_W  register-file read port B
//  ex_result      in   DATA_W  ALU result of instruction now in EX
//  mem_result     in   DATA_W  value in MEM stage
//  wb_result      in   DATA_W  value being written back
//  id_valid       in   1       decode slot holds a real instruction
//  id_rd          in   2       decode destination register
//  id_reg_write   in   1       decode instruction writes rd
//  id_mem_read    in   1       decode instruction is a load
//  if_id_hold     out  1       freeze PC and IF/ID (combinational = stall & ~flush)
//  ex_op_a        out  DATA_W  registered operand A
//  ex_op_b        out  DATA_W  registered operand B
//  ex_rd          out  2       registered destination
//  ex_reg_write   out  1       registered write enable (0 in bubble)
//  ex_mem_read    out  1       registered load flag (0 in bubble)
//  ex_valid       out  1       EX holds a real instruction
//  stall_timeout  out  1       sticky: stall run reached MAX_STALL
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all registered outputs 0, FSM=RUN, run counter 0.
//  - Operand mux (comb): 00->rf, 11->ex_result, 01->mem_result, 10->wb_result; A and B independent.
//  - Per edge, priority: reset > flush > stall > capture.
//  - flush: bubble (ex_valid, ex_reg_write, ex_mem_read = 0; ex_op_a/b, ex_rd = 0); flush beats stall.
//  - stall: bubble into EX, ex_op_a/b and ex_rd hold previous value; if_id_hold=1 same cycle.
//  - capture: all ex_* <= muxed operands / id_* fields, ex_valid <= id_valid; latency 1 cycle.
//  - id_valid=0 captures as bubble: reg_write and mem_read forced 0 regardless of id_* inputs.
//  - FSM RUN: stall=1 -> STALL, run=1. STALL: stall=1 -> run+1; stall=0 or flush -> RUN, run=0.
//  - run reaching MAX_STALL in STALL -> FAULT; FAULT sets stall_timeout=1, sticky until reset.
//  - FAULT keeps pipeline function as in RUN/STALL (monitor only); run counter saturates.
//  - Run counter 8 bits, never wraps.
// CONFIGURATION
//  STALL_PERF_EN defined:
//  - adds output stall_total [15:0]: cycles with stall=1 & flush=0 since reset.
//  - saturates at 16'hFFFF; 0 on reset.
//  Undefined: port absent, no counter logic.
// TESTING
//  - Reset: rst_n=0 2 cycles with inputs active -> all ex_* 0, stall_timeout 0.
//  - Forwarding: rf_rs=8'h11, ex=8'h22, mem=8'h33, wb=8'h44.
//    fa=11/01/10/00 on successive cycles -> ex_op_a 22,33,44,11 one cycle later; same for B.
//  - Load-use stall: capture id_rd=2, then stall=1 one cycle.
//    -> if_id_hold=1, next ex_valid=0, ex_reg_write=0, ex_op_a unchanged.
//  - Flush+stall same cycle -> if_id_hold=0, bubble with ex_op_a=0, ex_rd=0.
//  - Timeout: MAX_STALL=4, stall held 4 cycles -> stall_timeout=1 after 4th edge, stays 1 after stall drops.
//    3-cycle stall -> stays 0.
//  - STALL_PERF_EN: 3 stalls, 1 flush+stall, 2 idle -> stall_total=3; mid-run reset -> 0.

Source files
------------

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with operand forwarding, stall/flush bubble insertion
// and a stall run-length monitor that raises a sticky stall_timeout.
// Optional feature: define STALL_PERF_EN to add the stall_total performance counter.
module id_ex_forward_stage #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_STALL = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              id_valid,
    input  logic [1:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    output logic              if_id_hold,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [1:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_valid,
    output logic              stall_timeout
`ifdef STALL_PERF_EN
    ,
    output logic [15:0]       stall_total
`endif
);

    typedef enum logic [1:0] {StRun, StStall, StFault} state_e;

    localparam logic [7:0] MaxStallC = 8'(MAX_STALL);

    logic [DATA_W-1:0] op_a_mux, op_b_mux;
    logic [DATA_W-1:0] ex_op_a_d, ex_op_a_q, ex_op_b_d, ex_op_b_q;
    logic [1:0]        ex_rd_d, ex_rd_q;
    logic              ex_reg_write_d, ex_reg_write_q;
    logic              ex_mem_read_d, ex_mem_read_q;
    logic              ex_valid_d, ex_valid_q;
    logic              stall_eff;
    state_e            state_d, state_q;
    logic [7:0]        run_d, run_q, run_inc;
    logic              timeout_d, timeout_q;

    // Flush wins over stall, so a flushed stall neither holds IF/ID nor counts as a stall.
    assign stall_eff  = stall & ~flush;
    assign if_id_hold = stall_eff;

    // Forwarding muxes for both operands.
    always_comb begin
        case (forward_a)
            2'b00:   op_a_mux = rf_rs_data;
            2'b11:   op_a_mux = ex_result;
            2'b01:   op_a_mux = mem_result;
            default: op_a_mux = wb_result;
        endcase
        case (forward_b)
            2'b00:   op_b_mux = rf_rt_data;
            2'b11:   op_b_mux = ex_result;
            2'b01:   op_b_mux = mem_result;
            default: op_b_mux = wb_result;
        endcase
    end

    // EX register next state: flush bubble > stall bubble (payload held) > capture.
    always_comb begin
        ex_op_a_d      = ex_op_a_q;
        ex_op_b_d      = ex_op_b_q;
        ex_rd_d        = ex_rd_q;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_valid_d     = 1'b0;
        if (flush) begin
            ex_op_a_d = '0;
            ex_op_b_d = '0;
            ex_rd_d   = '0;
        end else if (!stall) begin
            ex_op_a_d      = op_a_mux;
            ex_op_b_d      = op_b_mux;
            ex_rd_d        = id_rd;
            ex_valid_d     = id_valid;
            ex_reg_write_d = id_valid & id_reg_write;
            ex_mem_read_d  = id_valid & id_mem_read;
        end
    end

    // Stall monitor next state; FAULT only observes, the pipeline is unaffected.
    always_comb begin
        run_inc   = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        state_d   = state_q;
        run_d     = run_q;
        timeout_d = timeout_q;
        case (state_q)
            StRun: begin
                if (stall_eff) begin
                    run_d = 8'd1;
                    if (8'd1 >= MaxStallC) begin
                        state_d   = StFault;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = StStall;
                    end
                end
            end
            StStall: begin
                if (stall_eff) begin
                    run_d = run_inc;
                    if (run_inc >= MaxStallC) begin
                        state_d   = StFault;
                        timeout_d = 1'b1;
                    end
                end else begin
                    run_d   = 8'd0;
                    state_d = StRun;
                end
            end
            StFault: begin
                timeout_d = 1'b1;
                run_d     = stall_eff ? run_inc : 8'd0;
            end
            default: begin
                state_d = StRun;
                run_d   = 8'd0;
            end
        endcase
    end

    // All state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_op_a_q      <= '0;
            ex_op_b_q      <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_valid_q     <= 1'b0;
            state_q        <= StRun;
            run_q          <= 8'd0;
            timeout_q      <= 1'b0;
        end else begin
            ex_op_a_q      <= ex_op_a_d;
            ex_op_b_q      <= ex_op_b_d;
            ex_rd_q        <= ex_rd_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_valid_q     <= ex_valid_d;
            state_q        <= state_d;
            run_q          <= run_d;
            timeout_q      <= timeout_d;
        end
    end

    assign ex_op_a       = ex_op_a_q;
    assign ex_op_b       = ex_op_b_q;
    assign ex_rd         = ex_rd_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_valid      = ex_valid_q;
    assign stall_timeout = timeout_q;

`ifdef STALL_PERF_EN
    logic [15:0] stall_total_d, stall_total_q;

    // Saturating count of effective stall cycles.
    always_comb begin
        stall_total_d = stall_total_q;
        if (stall_eff && stall_total_q != 16'hFFFF) begin
            stall_total_d = stall_total_q + 16'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_total_q <= 16'd0;
        end else begin
            stall_total_q <= stall_total_d;
        end
    end

    assign stall_total = stall_total_q;
`endif

endmodule
